// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared text-buffer geometry, pipeline side-band types and address packing
package text_pkg;

  localparam int TEXT_COLS         = 70;
  localparam int TEXT_ROWS         = 30;
  localparam int GLYPH_W           = 9;
  localparam int GLYPH_H           = 16;
  localparam int TEXT_AW           = 12;
  localparam int ROW_STRIDE        = 128;
  localparam int COL_W             = 7;
  localparam int ROW_W             = 5;
  localparam int PX_W              = 4;
  localparam int GR_W              = 4;
  localparam int RGB_W             = 24;
  localparam int BLINK_DIV_DEFAULT = 12500000;

  // Side-band carried from stage 0 into stage 1 (glyph row still needed for the font address)
  typedef struct packed {
    logic [PX_W-1:0]  px;
    logic [GR_W-1:0]  gr;
    logic             valid;
    logic             hs;
    logic             vs;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } s1_t;

  // Side-band carried from stage 1 into stage 2 (pixel select, cursor match, syncs)
  typedef struct packed {
    logic [PX_W-1:0]  px;
    logic             valid;
    logic             hs;
    logic             vs;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } s2_t;

  // Text RAM address: rows are ROW_STRIDE (128) cells apart, so the address is a plain concat
  function automatic logic [TEXT_AW-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_text_reader_if.sv
// rtl/vga_text_reader_if.sv - read bus to the external text RAM and font ROM
interface vga_text_reader_if;
  import text_pkg::*;

  logic [TEXT_AW-1:0] char_addr;
  logic [7:0]         char_data;
  logic [TEXT_AW-1:0] font_addr;
  logic [GLYPH_W-1:0] font_data;

  modport master (output char_addr, output font_addr, input char_data, input font_data);
  modport slave  (input char_addr, input font_addr, output char_data, output font_data);

endinterface

// File: rtl/div9_u10.sv
// rtl/div9_u10.sv - combinational divide of a 10-bit pixel x by the glyph width 9
module div9_u10
  import text_pkg::*;
(
  input  logic [9:0]       h_addr,
  output logic [COL_W-1:0] col,
  output logic [PX_W-1:0]  px
);

  logic [19:0] prod;
  logic [9:0]  rem;
  logic        unused_bits;

  // Reciprocal multiply: 911/8192 overestimates 1/9 by 7/73728, exact for every h below 1170
  always_comb begin
    prod = 20'(h_addr) * 20'd911;
    col  = prod[19:13];
    rem  = h_addr - (10'(col) * 10'(GLYPH_W));
    px   = rem[PX_W-1:0];
  end

  assign unused_bits = ^{prod[12:0], rem[9:PX_W]};

endmodule

// File: rtl/vga_text_reader.sv
// rtl/vga_text_reader.sv - 3-stage text-mode pixel pipeline with blinking block cursor
module vga_text_reader #(
  parameter int          COLS      = text_pkg::TEXT_COLS,
  parameter int          ROWS      = text_pkg::TEXT_ROWS,
  parameter int          BLINK_DIV = text_pkg::BLINK_DIV_DEFAULT,
  parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [9:0]         h_addr,
  input  logic [8:0]         v_addr,
  input  logic               valid_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [6:0]         cur_col,
  input  logic [4:0]         cur_row,
  input  logic               cur_en,
  vga_text_reader_if.master  mem,
  output logic [23:0]        vga_data,
  output logic               hsync,
  output logic               vsync,
  output logic               valid
);
  import text_pkg::*;

  localparam int               BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);
  // Syncs are active low, so their side-band resets to the inactive level
  localparam s1_t S1_RESET = '{px: '0, gr: '0, valid: 1'b0, hs: 1'b1, vs: 1'b1,
                               col: '0, row: '0};
  localparam s2_t S2_RESET = '{px: '0, valid: 1'b0, hs: 1'b1, vs: 1'b1, col: '0, row: '0};

  logic [COL_W-1:0] col0;
  logic [COL_W-1:0] col_sat;
  logic [PX_W-1:0]  px0;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [BW-1:0]    blink_cnt_d, blink_cnt_q;
  logic             blink_d, blink_q;
  logic             glyph_bit;
  logic             cursor_hit;
  logic [23:0]      vga_data_d, vga_data_q;
  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             valid_d, valid_q;

  div9_u10 u_div9 (
    .h_addr (h_addr),
    .col    (col0),
    .px     (px0)
  );

  // Stage 0: text RAM address; the right-margin cells reuse the last visible column
  always_comb begin
    col_sat       = (col0 >= COL_LAST) ? COL_LAST : col0;
    mem.char_addr = clrn ? pack_addr(v_addr[8:4], col_sat) : '0;
  end

  // Stage 0 side-band: keep the unsaturated column so stage 2 can spot the margin
  always_comb begin
    s1_d       = S1_RESET;
    s1_d.px    = px0;
    s1_d.gr    = v_addr[3:0];
    s1_d.valid = valid_in;
    s1_d.hs    = hsync_in;
    s1_d.vs    = vsync_in;
    s1_d.col   = col0;
    s1_d.row   = v_addr[8:4];
  end

  // Stage 1: font address from the character just returned by the text RAM
  always_comb begin
    mem.font_addr = clrn ? {mem.char_data, s1_q.gr} : '0;
    s2_d          = S2_RESET;
    s2_d.px       = s1_q.px;
    s2_d.valid    = s1_q.valid;
    s2_d.hs       = s1_q.hs;
    s2_d.vs       = s1_q.vs;
    s2_d.col      = s1_q.col;
    s2_d.row      = s1_q.row;
  end

  // Cursor blink: free-running half-period counter, phase flips on each wrap
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Stage 2: pick the glyph bit, invert it under the cursor, blank outside the text area
  always_comb begin
    glyph_bit  = mem.font_data[s2_q.px];
    cursor_hit = cur_en & blink_q & (s2_q.col == cur_col) & (s2_q.row == cur_row);
    vga_data_d = BG_COLOR;
    if (!s2_q.valid) begin
      vga_data_d = '0;
    end else if ((s2_q.col >= COL_END) || (s2_q.row >= ROW_END)) begin
      vga_data_d = BG_COLOR;
    end else if (glyph_bit ^ cursor_hit) begin
      vga_data_d = FG_COLOR;
    end
    hsync_d = s2_q.hs;
    vsync_d = s2_q.vs;
    valid_d = s2_q.valid;
  end

  // Pipeline, blink and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_q        <= S1_RESET;
      s2_q        <= S2_RESET;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      vga_data_q  <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      vga_data_q  <= vga_data_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      valid_q     <= valid_d;
    end
  end

  assign vga_data = vga_data_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_vga_text_reader.sv
// tb/tb_vga_text_reader.sv - scoreboard bench for vga_text_reader
module tb_vga_text_reader;

  localparam logic [23:0] FG = 24'hF0E0D0;
  localparam logic [23:0] BG = 24'h102030;
  localparam int          BD = 4;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [9:0]  h_addr = '0;
  logic [8:0]  v_addr = '0;
  logic        valid_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [6:0]  cur_col = '0;
  logic [4:0]  cur_row = '0;
  logic        cur_en = 1'b0;
  logic [23:0] vga_data;
  logic        hsync, vsync, valid;

  vga_text_reader_if mem_if ();

  vga_text_reader #(
    .COLS(70), .ROWS(30), .BLINK_DIV(BD), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .clrn(clrn), .h_addr(h_addr), .v_addr(v_addr), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cur_col(cur_col), .cur_row(cur_row),
    .cur_en(cur_en), .mem(mem_if), .vga_data(vga_data), .hsync(hsync), .vsync(vsync),
    .valid(valid)
  );

  logic [7:0] ram  [4096];
  logic [8:0] font [4096];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_if.char_data <= ram[mem_if.char_addr];
    mem_if.font_data <= font[mem_if.font_addr];
  end

  int cyc = 0;
  int ecnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge clrn)
    if (!clrn) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  typedef struct {
    int          due;
    logic [23:0] d;
    logic        hs;
    logic        vs;
    logic        vl;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [23:0] model_px(input int h, input int v, input logic val, input int n);
    int col, px, row, gr, fidx;
    logic [7:0] a;
    logic [8:0] f;
    logic bl, hit;
    col = h / 9;  px = h % 9;  row = v / 16;  gr = v % 16;
    if (!val) return 24'h0;
    if (col >= 70) return BG;
    a    = ram[row * 128 + col];
    fidx = int'(a) * 16 + gr;
    f    = font[fidx];
    bl   = (((n + 2) / BD) % 2) == 1;
    hit  = cur_en && bl && (int'(cur_col) == col) && (int'(cur_row) == row);
    return (f[px] ^ hit) ? FG : BG;
  endfunction

  task automatic tick(input int h, input int v, input logic val, input logic hs,
                      input logic vs, input bit push);
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_cmp++; n_err++;
      $display("FAIL sb_lost: item due cyc %0d unseen at cyc %0d", e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if ({vga_data, hsync, vsync, valid} !== {e.d, e.hs, e.vs, e.vl}) begin
        n_err++;
        $display("FAIL pixel cyc %0d: got rgb=%h hs=%b vs=%b valid=%b, expected rgb=%h hs=%b vs=%b valid=%b",
                 cyc, vga_data, hsync, vsync, valid, e.d, e.hs, e.vs, e.vl);
      end
    end
    h_addr = 10'(h); v_addr = 9'(v); valid_in = val; hsync_in = hs; vsync_in = vs;
    if (push) begin
      e.due = cyc + 3;
      e.d   = model_px(h, v, val, ecnt);
      e.hs  = hs; e.vs = vs; e.vl = val;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d items still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({vga_data, hsync, vsync, valid} !== {24'h0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL %s outputs: got rgb=%h hs=%b vs=%b valid=%b, required 000000 1 1 0",
               tag, vga_data, hsync, vsync, valid);
    end
    n_cmp++;
    if ({mem_if.char_addr, mem_if.font_addr} !== 24'h0) begin
      n_err++;
      $display("FAIL %s addrs: got char_addr=%h font_addr=%h, required 000 000",
               tag, mem_if.char_addr, mem_if.font_addr);
    end
  endtask

  task automatic test_reset();
    h_addr = 10'd300; v_addr = 9'd200; valid_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_addressing();
    logic [11:0] exp_a [4] = '{12'h102, 12'hEC5, 12'h045, 12'h102};
    int hs_t [4] = '{18, 629, 635, 18};
    int vs_t [4] = '{35, 479, 0, 35};
    for (int i = 0; i < 4; i++) begin
      tick(hs_t[i], vs_t[i], (i != 3), 1'b1, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (mem_if.char_addr !== exp_a[i]) begin
        n_err++;
        $display("FAIL char_addr h=%0d v=%0d: got %h, required %h",
                 hs_t[i], vs_t[i], mem_if.char_addr, exp_a[i]);
      end
    end
    drain();
  endtask

  task automatic test_glyph();
    ram[0] = 8'h41;
    font[12'h410] = 9'b000010000;
    tick(4, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(3, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (mem_if.font_addr !== 12'h410) begin
      n_err++;
      $display("FAIL font_addr: got %h, required 410", mem_if.font_addr);
    end
    for (int h = 0; h < 18; h++) tick(h, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_latency();
    for (int i = 0; i < 16; i++)
      tick(9 * i, 5, (i % 3) != 0, 1'(i % 2), 1'((i / 4) % 2), 1'b1);
    drain();
  endtask

  task automatic test_cursor();
    ram[0] = 8'h00;
    cur_col = 7'd0; cur_row = 5'd0; cur_en = 1'b1;
    for (int i = 0; i < 16; i++) tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
    cur_en = 1'b0;
    for (int i = 0; i < 8; i++) tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_margin();
    for (int c = 0; c < 70; c++) ram[c] = 8'h41;
    for (int g = 0; g < 16; g++) font[12'h410 + g] = 9'h1FF;
    for (int v = 0; v < 3; v++)
      for (int h = 620; h < 640; h++) tick(h, v, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int h = 630; h < 640; h++) tick(h, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_random();
    for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
    for (int a = 16; a < 4096; a++) font[a] = 9'($urandom);
    cur_col = 7'd5; cur_row = 5'd3; cur_en = 1'b1;
    for (int i = 0; i < 200; i++)
      tick($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), 1'b1);
    for (int v = 48; v < 52; v++)
      for (int h = 45; h < 54; h++) tick(h, v, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
    cur_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    for (int h = 0; h < 6; h++) tick(h, 17, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    sb.delete();
    @(negedge clk);
    clrn = 1'b1;
    for (int h = 6; h < 24; h++) tick(h, 17, 1'b1, 1'(h % 2), 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram[a] = 8'h00;
      font[a] = 9'h000;
    end
    test_reset();
    test_addressing();
    test_glyph();
    test_latency();
    test_cursor();
    test_margin();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
